// File: rtl/simple_computer_pkg.sv
// Shared definitions for the Simple Computer: fetch state encoding, the HALT
// opcode, and default widths common to the instruction ROM, fetch and decode.
package simple_computer_pkg;

   localparam int unsigned DataWidthDef   = 16;
   localparam int unsigned AddrWidthDef   = 6;
   localparam int unsigned OpcodeWidthDef = 7;

   localparam logic [OpcodeWidthDef-1:0] HaltOpcodeDef = 7'h7F;

   // Fetch FSM encoding
   localparam logic StRun    = 1'b0;
   localparam logic StHalted = 1'b1;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register.
//   clk_i       : clock
//   rst_i       : synchronous active-high reset, clears PC to 0
//   load_i      : load PC from load_addr_i (takes priority over inc_i)
//   load_addr_i : redirect target
//   inc_i       : increment PC by one, wrapping modulo 2^ADDR_WIDTH
//   pc_o        : current PC
module fetch_pc_reg #(
   parameter int unsigned ADDR_WIDTH = 6
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic [ADDR_WIDTH-1:0] load_addr_i,
   input  logic                  inc_i,
   output logic [ADDR_WIDTH-1:0] pc_o
);

   logic [ADDR_WIDTH-1:0] pc_d, pc_q;

   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = load_addr_i;
      end else if (inc_i) begin
         pc_d = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the combinational instruction ROM,
// holds the fetched word in an instruction register offered to decode with a
// valid/ready handshake, applies branch/jump redirects and stops on HALT.
//   clk, rst       : clock, synchronous active-high reset
//   rom_addr       : ROM address (equals PC)
//   rom_data       : ROM word for rom_addr, same cycle
//   ir, ir_pc      : registered instruction and its fetch address
//   ir_valid       : ir holds an unconsumed instruction
//   ir_ready       : decode accepts ir this cycle
//   redirect_valid : load PC from redirect_addr and flush ir
//   redirect_addr  : redirect target
//   halted         : HALT fetched, PC frozen until reset
module instruction_fetch_unit
   import simple_computer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DataWidthDef,
   parameter int unsigned ADDR_WIDTH   = AddrWidthDef,
   parameter int unsigned OPCODE_WIDTH = OpcodeWidthDef,
   parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = HaltOpcodeDef
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic [DATA_WIDTH-1:0] ir,
   output logic [ADDR_WIDTH-1:0] ir_pc,
   output logic                  ir_valid,
   input  logic                  ir_ready,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_addr,
   output logic                  halted
);

   logic                  state_d, state_q;
   logic [DATA_WIDTH-1:0] ir_d, ir_q;
   logic [ADDR_WIDTH-1:0] ir_pc_d, ir_pc_q;
   logic                  ir_valid_d, ir_valid_q;
   logic [ADDR_WIDTH-1:0] pc;
   logic                  fetch, redirect, is_halt;

   // Redirect outranks both fetch and stall; it is ignored once halted.
   assign redirect = (state_q == StRun) && redirect_valid;
   assign fetch    = (state_q == StRun) && !redirect_valid && (!ir_valid_q || ir_ready);
   assign is_halt  = (rom_data[DATA_WIDTH-1 -: OPCODE_WIDTH] == HALT_OPCODE);

   fetch_pc_reg #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_pc (
      .clk_i       (clk),
      .rst_i       (rst),
      .load_i      (redirect),
      .load_addr_i (redirect_addr),
      .inc_i       (fetch),
      .pc_o        (pc)
   );

   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = ir_valid_q;
      if (redirect) begin
         ir_valid_d = 1'b0;
      end else if (fetch) begin
         ir_d       = rom_data;
         ir_pc_d    = pc;
         ir_valid_d = 1'b1;
         if (is_halt) begin
            state_d = StHalted;
         end
      end else if (ir_valid_q && ir_ready) begin
         // Accepted with nothing new behind it (only reachable when halted)
         ir_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StRun;
         ir_q       <= '0;
         ir_pc_q    <= '0;
         ir_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         ir_pc_q    <= ir_pc_d;
         ir_valid_q <= ir_valid_d;
      end
   end

   assign rom_addr = pc;
   assign ir       = ir_q;
   assign ir_pc    = ir_pc_q;
   assign ir_valid = ir_valid_q;
   assign halted   = (state_q == StHalted);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  rom_addr;
   logic [15:0] rom_data;
   logic [15:0] ir;
   logic [5:0]  ir_pc;
   logic        ir_valid;
   logic        ir_ready;
   logic        redirect_valid;
   logic [5:0]  redirect_addr;
   logic        halted;

   logic [15:0] rom [64];

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   // ROM model: combinational read, drives 0 during reset
   assign rom_data = rst ? 16'h0000 : rom[rom_addr];

   instruction_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .ir             (ir),
      .ir_pc          (ir_pc),
      .ir_valid       (ir_valid),
      .ir_ready       (ir_ready),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .halted         (halted)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance one clock edge and settle 1 time unit past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 16'h5000 | 16'(i);
      rom[0] = 16'h1001;
      rom[1] = 16'h1002;
      rom[2] = 16'h1003;
      rom[3] = 16'hFE00;
      rst = 1'b1;
      ir_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_addr = '0;
      step();
      step();
      check("rst_ir_valid", 32'(ir_valid), 0);
      check("rst_ir", 32'(ir), 0);
      check("rst_ir_pc", 32'(ir_pc), 0);
      check("rst_halted", 32'(halted), 0);
      check("rst_rom_addr", 32'(rom_addr), 0);

      // Straight-line run into HALT
      rst = 1'b0;
      step();
      check("seq0_ir", 32'(ir), 32'h1001);
      check("seq0_pc", 32'(ir_pc), 0);
      check("seq0_valid", 32'(ir_valid), 1);
      step();
      check("seq1_ir", 32'(ir), 32'h1002);
      check("seq1_pc", 32'(ir_pc), 1);
      step();
      check("seq2_ir", 32'(ir), 32'h1003);
      check("seq2_pc", 32'(ir_pc), 2);
      check("seq2_halted", 32'(halted), 0);
      step();
      check("seq3_ir", 32'(ir), 32'hFE00);
      check("seq3_pc", 32'(ir_pc), 3);
      check("seq3_halted", 32'(halted), 1);
      check("seq3_rom_addr", 32'(rom_addr), 4);
      step();
      check("halt_valid_drop", 32'(ir_valid), 0);
      check("halt_rom_addr_a", 32'(rom_addr), 4);
      step();
      check("halt_rom_addr_b", 32'(rom_addr), 4);
      check("halt_still", 32'(halted), 1);

      // Stall test
      rom[3] = 16'h1004;
      rst = 1'b1;
      step();
      check("rst2_halted", 32'(halted), 0);
      check("rst2_valid", 32'(ir_valid), 0);
      rst = 1'b0;
      step();
      check("st_ir0", 32'(ir), 32'h1001);
      step();
      check("st_ir1", 32'(ir), 32'h1002);
      ir_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("stall_ir", 32'(ir), 32'h1002);
         check("stall_ir_pc", 32'(ir_pc), 1);
         check("stall_rom_addr", 32'(rom_addr), 2);
         check("stall_valid", 32'(ir_valid), 1);
      end
      ir_ready = 1'b1;
      step();
      check("unstall_ir", 32'(ir), 32'h1003);
      check("unstall_ir_pc", 32'(ir_pc), 2);

      // Reset during a stall
      ir_ready = 1'b0;
      step();
      check("stall2_ir", 32'(ir), 32'h1003);
      rst = 1'b1;
      step();
      check("rst3_valid", 32'(ir_valid), 0);
      check("rst3_pc", 32'(rom_addr), 0);
      check("rst3_halted", 32'(halted), 0);
      rst = 1'b0;
      ir_ready = 1'b1;
      step();
      check("restart_ir", 32'(ir), 32'h1001);
      check("restart_ir_pc", 32'(ir_pc), 0);

      // Run to pc=5, then redirect to 0x20
      step();
      step();
      step();
      step();
      check("pre_redir_ir_pc", 32'(ir_pc), 4);
      check("pre_redir_addr", 32'(rom_addr), 5);
      redirect_valid = 1'b1;
      redirect_addr = 6'h20;
      step();
      redirect_valid = 1'b0;
      check("redir_flush", 32'(ir_valid), 0);
      check("redir_rom_addr", 32'(rom_addr), 32'h20);
      step();
      check("redir_ir", 32'(ir), 32'h5020);
      check("redir_ir_pc", 32'(ir_pc), 32'h20);
      check("redir_valid", 32'(ir_valid), 1);

      // Wrap from 63 to 0
      rom[63] = 16'h2000;
      redirect_valid = 1'b1;
      redirect_addr = 6'd63;
      step();
      redirect_valid = 1'b0;
      check("wrap_flush", 32'(ir_valid), 0);
      step();
      check("wrap_ir63", 32'(ir), 32'h2000);
      check("wrap_ir_pc63", 32'(ir_pc), 63);
      check("wrap_rom_addr", 32'(rom_addr), 0);
      step();
      check("wrap_ir0", 32'(ir), 32'h1001);
      check("wrap_ir_pc0", 32'(ir_pc), 0);

      // Redirect in the same cycle a HALT word is presented
      rom[1] = 16'hFE00;
      check("pre_rh_addr", 32'(rom_addr), 1);
      redirect_valid = 1'b1;
      redirect_addr = 6'd10;
      step();
      redirect_valid = 1'b0;
      check("rh_halted", 32'(halted), 0);
      check("rh_valid", 32'(ir_valid), 0);
      step();
      check("rh_ir_pc", 32'(ir_pc), 10);
      check("rh_ir", 32'(ir), 32'h500A);
      check("rh_halted2", 32'(halted), 0);

      // Reach HALT, then a redirect pulse must be ignored
      redirect_valid = 1'b1;
      redirect_addr = 6'd1;
      step();
      redirect_valid = 1'b0;
      step();
      check("h2_ir", 32'(ir), 32'hFE00);
      check("h2_ir_pc", 32'(ir_pc), 1);
      check("h2_halted", 32'(halted), 1);
      check("h2_rom_addr", 32'(rom_addr), 2);
      redirect_valid = 1'b1;
      redirect_addr = 6'd40;
      step();
      redirect_valid = 1'b0;
      check("h2_redir_ignored", 32'(rom_addr), 2);
      check("h2_accepted", 32'(ir_valid), 0);
      check("h2_halted_b", 32'(halted), 1);
      step();
      check("h2_frozen", 32'(rom_addr), 2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
